display_value_ctrl: RTL and testbench
=====================================

Name: display_value_ctrl

Overview:
- Controller that sequences the 3-digit-plus-sign seven-segment display path.
- Accepts a signed binary value over a valid/ready handshake and converts it to sign-magnitude BCD with an iterative shift-add-3 (double-dabble) engine.
- Holds the results on registered digit/sign/enable outputs that drive the display block's dig2/dig1/dig0, negative_sign and en inputs.
- Sits between arithmetic datapaths (counters, ALU results) and the display multiplexer.

Parameters:
- WIDTH, 10, input width, two's complement; legal range 4..13.
- SAT_VALUE, 999, magnitude shown when the value exceeds 3 digits.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- in_valid  in  1  upstream has a value on in_value
- in_value  in  WIDTH  signed value to display
- in_ready  out  1  controller can accept a value
- dig2  out  4  hundreds digit code to display
- dig1  out  4  tens digit code
- dig0  out  4  units digit code
- negative_sign  out  1  value negative (display shows minus)
- disp_en  out  1  display enable; low until the first conversion completes
- overflow  out  1  last value had |v| > 999; digits saturated
- done  out  1  one-cycle pulse when the outputs update

Behaviour:
- Reset (rst=0, async):
  - FSM to IDLE; in_ready=1.
  - dig2/dig1/dig0 = 0.
  - negative_sign=0, disp_en=0, overflow=0, done=0.
  - Internal shift/BCD registers cleared.
- FSM states: IDLE, CONVERT, LATCH.
- IDLE:
  - in_ready=1.
  - Accept on a clk edge with in_valid&&in_ready.
  - Capture sign = in_value[WIDTH-1].
  - Capture magnitude = |in_value| as unsigned WIDTH bits; -2^(WIDTH-1) maps to 2^(WIDTH-1), which is exact.
  - Clear the 4-digit BCD accumulator; load shift counter = WIDTH; go to CONVERT.
- CONVERT:
  - in_ready=0.
  - Each cycle: every BCD digit >=5 gets +3, then {bcd,mag} shifts left 1; counter decrements.
  - Go to LATCH after exactly WIDTH shift cycles.
- LATCH (1 cycle):
  - If the thousands digit != 0: overflow=1 and the digits take SAT_VALUE's digits (9,9,9).
  - Otherwise: overflow=0 and the digits take the BCD hundreds/tens/units.
  - negative_sign = sign AND magnitude != 0; zero never shows minus.
  - disp_en=1; done=1 for this cycle only.
  - Return to IDLE.
- Latency: outputs and done update on the edge WIDTH+1 cycles after the accepting edge (WIDTH=10 gives 11 cycles). in_ready is high again the cycle after LATCH.
- Max throughput: one value per WIDTH+2 cycles.
- Output registers hold the last result between conversions. A conversion in flight never alters the displayed value until LATCH.
- in_valid while busy is ignored. in_value need not stay stable after acceptance; upstream holds in_valid until in_ready.
- Reset mid-CONVERT aborts the conversion; all outputs return to reset values, including disp_en=0.
- Digit codes: 0-9 are numerals, 10 = minus, 11 = blank. This block emits only 0-9 and 11 (11 only under the optional feature).

Optional Feature:
- Macro: DISPLAY_BLANK_LEADING_ZEROS_EN.
- Defined, applied at LATCH:
  - dig2=0 is replaced by 11 (blank).
  - If dig2 is blanked and dig1=0, dig1 is also replaced by 11.
  - dig0 is never blanked.
- Not defined: leading zeros are shown as 0.

Decomposition:
- Package display_pkg:
  - state enum {IDLE, CONVERT, LATCH}.
  - constants DIG_MINUS=10, DIG_BLANK=11, BCD_DIGITS=4, MAX_DISPLAY=999.
  - digit-code typedef (4-bit).
- One combinational sub-module, bcd_adjust: takes 16-bit packed BCD, applies add-3 to each nibble >=5. Instantiated once in the CONVERT path.

Test Plan:
- Reset then idle → all outputs 0, disp_en=0, in_ready=1; no done pulse.
- in_value=123 (WIDTH=10) accepted at edge k → at edge k+11: done=1, digits 1,2,3, negative_sign=0, overflow=0, disp_en=1; in_ready=1 at k+12.
- in_value=-45 → digits 0,4,5, negative_sign=1. With DISPLAY_BLANK_LEADING_ZEROS_EN → dig2=11, dig1=4, dig0=5.
- in_value=-512 then 511 back-to-back, in_valid held high → second value accepted only after in_ready returns. Both at 12-cycle spacing: -512 gives 5,1,2 with minus; 511 gives 5,1,1, overflow=0. WIDTH=11 with 1023 → overflow=1, digits 9,9,9.
- in_value=0 with the sign bit pattern from -0 stimulus, and 0 → negative_sign=0, digits 0,0,0. With the macro → 11,11,0.
- Accept 777, assert rst=0 five cycles later → outputs immediately to reset values, no done pulse. Release, send 8 → digits 0,0,8 after 11 cycles.

Source files
------------

// File: rtl/display_value_ctrl_pkg.sv
// display_pkg: shared FSM states, digit codes and display constants for display_value_ctrl.
package display_pkg;
  typedef enum logic [1:0] {IDLE, CONVERT, LATCH} state_e;
  typedef logic [3:0] digit_t;
  localparam digit_t DIG_MINUS = 4'd10;
  localparam digit_t DIG_BLANK = 4'd11;
  localparam int BCD_DIGITS = 4;
  localparam int MAX_DISPLAY = 999;
endpackage

// File: rtl/display_value_ctrl_if.sv
// display_value_ctrl_if: value handshake plus registered digit/sign/enable outputs toward the display.
interface display_value_ctrl_if #(parameter int WIDTH = 10);
  import display_pkg::*;
  logic in_valid;
  logic [WIDTH-1:0] in_value;
  logic in_ready;
  digit_t dig2, dig1, dig0;
  logic negative_sign, disp_en, overflow, done;
  modport master (output in_valid, in_value, input in_ready, dig2, dig1, dig0, negative_sign, disp_en, overflow, done);
  modport slave (input in_valid, in_value, output in_ready, dig2, dig1, dig0, negative_sign, disp_en, overflow, done);
endinterface

// File: rtl/display_value_ctrl_bcd_adjust.sv
// bcd_adjust: add-3 correction applied to every packed BCD nibble that is 5 or more.
module bcd_adjust import display_pkg::*; (
  input  logic [4*BCD_DIGITS-1:0] bcd_i,
  output logic [4*BCD_DIGITS-1:0] bcd_o
);
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_nib
    assign bcd_o[4*g+:4] = (bcd_i[4*g+:4] >= 4'd5) ? bcd_i[4*g+:4] + 4'd3 : bcd_i[4*g+:4];
  end
endmodule

// File: rtl/display_value_ctrl.sv
// display_value_ctrl: signed value to sign-magnitude BCD via double-dabble, latched for the display.
// Define DISPLAY_BLANK_LEADING_ZEROS_EN to blank leading zero hundreds/tens digits.
module display_value_ctrl import display_pkg::*; #(
  parameter int WIDTH = 10,
  parameter int SAT_VALUE = 999
) (
  input logic clk,
  input logic rst,
  display_value_ctrl_if.slave bus
);
  localparam digit_t SAT2 = digit_t'((SAT_VALUE / 100) % 10);
  localparam digit_t SAT1 = digit_t'((SAT_VALUE / 10) % 10);
  localparam digit_t SAT0 = digit_t'(SAT_VALUE % 10);
  state_e state_q, state_d;
  logic sign_q, sign_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [15:0] bcd_q, bcd_d, adj;
  logic [4:0] cnt_q, cnt_d;
  digit_t dig2_q, dig2_d, dig1_q, dig1_d, dig0_q, dig0_d;
  logic neg_q, neg_d, en_q, en_d, ovf_q, ovf_d, done_q, done_d;
  digit_t hun, ten;
  logic thou_nz;
  bcd_adjust u_adj (.bcd_i(bcd_q), .bcd_o(adj));
  assign thou_nz = bcd_q[15:12] != 4'd0;
`ifdef DISPLAY_BLANK_LEADING_ZEROS_EN
  assign hun = (bcd_q[11:8] == 4'd0) ? DIG_BLANK : bcd_q[11:8];
  assign ten = (bcd_q[11:4] == 8'd0) ? DIG_BLANK : bcd_q[7:4];
`else
  assign hun = bcd_q[11:8];
  assign ten = bcd_q[7:4];
`endif
  always_comb begin
    state_d = state_q;
    sign_d = sign_q;
    mag_d = mag_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    dig2_d = dig2_q;
    dig1_d = dig1_q;
    dig0_d = dig0_q;
    neg_d = neg_q;
    en_d = en_q;
    ovf_d = ovf_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        sign_d = bus.in_value[WIDTH-1];
        mag_d = bus.in_value[WIDTH-1] ? -bus.in_value : bus.in_value;
        bcd_d = '0;
        cnt_d = 5'(WIDTH);
        state_d = CONVERT;
      end
      CONVERT: begin
        bcd_d = (adj << 1) | 16'(mag_q[WIDTH-1]);
        mag_d = mag_q << 1;
        cnt_d = cnt_q - 5'd1;
        state_d = (cnt_q == 5'd1) ? LATCH : CONVERT;
      end
      LATCH: begin
        ovf_d = thou_nz;
        dig2_d = thou_nz ? SAT2 : hun;
        dig1_d = thou_nz ? SAT1 : ten;
        dig0_d = thou_nz ? SAT0 : bcd_q[3:0];
        // a nonzero BCD result is the only proof the magnitude was nonzero
        neg_d = sign_q && (bcd_q != 16'd0);
        en_d = 1'b1;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sign_q <= 1'b0;
      mag_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      dig2_q <= '0;
      dig1_q <= '0;
      dig0_q <= '0;
      neg_q <= 1'b0;
      en_q <= 1'b0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q <= sign_d;
      mag_q <= mag_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      dig2_q <= dig2_d;
      dig1_q <= dig1_d;
      dig0_q <= dig0_d;
      neg_q <= neg_d;
      en_q <= en_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.dig2 = dig2_q;
  assign bus.dig1 = dig1_q;
  assign bus.dig0 = dig0_q;
  assign bus.negative_sign = neg_q;
  assign bus.disp_en = en_q;
  assign bus.overflow = ovf_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_display_value_ctrl.sv
// tb_display_value_ctrl: table, hand-written and random checks of display_value_ctrl at WIDTH=10 and 11.
module tb_display_value_ctrl;
  import display_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  display_value_ctrl_if #(.WIDTH(10)) bus();
  display_value_ctrl_if #(.WIDTH(11)) bus11();
  display_value_ctrl #(.WIDTH(10)) dut (.clk(clk), .rst(rst), .bus(bus));
  display_value_ctrl #(.WIDTH(11)) dut11 (.clk(clk), .rst(rst), .bus(bus11));
  typedef struct {int v; int d2; int d1; int d0; bit neg; bit ovf;} vec_t;
  vec_t tbl[10];
  int vecs = 0, errs = 0;
  int p2 = 0, p1 = 0, p0 = 0;
  bit pneg = 0, povf = 0, pen = 0;
  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic void blank(inout int d2, inout int d1);
`ifdef DISPLAY_BLANK_LEADING_ZEROS_EN
    if (d2 == 0) begin
      d2 = 11;
      if (d1 == 0) d1 = 11;
    end
`endif
  endfunction
  function automatic void model(input int v, output int d2, output int d1, output int d0, output bit neg, output bit ovf);
    int m;
    m = v < 0 ? -v : v;
    ovf = m > 999;
    neg = v < 0;
    if (ovf) m = 999;
    d2 = m / 100;
    d1 = (m / 10) % 10;
    d0 = m % 10;
    blank(d2, d1);
  endfunction
  task automatic check_out(input string tag, input int d2, input int d1, input int d0, input bit neg, input bit ovf, input bit en);
    chk({tag, " dig2"}, int'(bus.dig2), d2);
    chk({tag, " dig1"}, int'(bus.dig1), d1);
    chk({tag, " dig0"}, int'(bus.dig0), d0);
    chk({tag, " neg"}, int'(bus.negative_sign), int'(neg));
    chk({tag, " ovf"}, int'(bus.overflow), int'(ovf));
    chk({tag, " en"}, int'(bus.disp_en), int'(en));
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.in_ready && n < 40) begin @(negedge clk); n++; end
    chk({tag, " ready"}, int'(bus.in_ready), 1);
  endtask
  task automatic wait_done(inout int n, input string tag, input int lat);
    while (!bus.done && n < 60) begin @(negedge clk); n++; end
    chk({tag, " latency"}, n, lat);
  endtask
  task automatic send(input int v, input int d2, input int d1, input int d0, input bit neg, input bit ovf, input string tag);
    int n = 0;
    wait_ready(tag);
    bus.in_valid = 1'b1;
    bus.in_value = 10'(v);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_value = 10'($urandom);
    chk({tag, " busy"}, int'(bus.in_ready), 0);
    check_out({tag, " hold"}, p2, p1, p0, pneg, povf, pen);
    wait_done(n, tag, 11);
    check_out(tag, d2, d1, d0, neg, ovf, 1'b1);
    chk({tag, " ready_after"}, int'(bus.in_ready), 1);
    p2 = d2; p1 = d1; p0 = d0; pneg = neg; povf = ovf; pen = 1'b1;
    @(negedge clk);
    chk({tag, " done_pulse"}, int'(bus.done), 0);
  endtask
  task automatic send11(input int v, input int d2, input int d1, input int d0, input bit neg, input bit ovf, input string tag);
    int n = 0;
    while (!bus11.in_ready && n < 40) begin @(negedge clk); n++; end
    bus11.in_valid = 1'b1;
    bus11.in_value = 11'(v);
    @(posedge clk);
    @(negedge clk);
    bus11.in_valid = 1'b0;
    n = 0;
    while (!bus11.done && n < 60) begin @(negedge clk); n++; end
    chk({tag, " latency"}, n, 12);
    chk({tag, " dig2"}, int'(bus11.dig2), d2);
    chk({tag, " dig1"}, int'(bus11.dig1), d1);
    chk({tag, " dig0"}, int'(bus11.dig0), d0);
    chk({tag, " neg"}, int'(bus11.negative_sign), int'(neg));
    chk({tag, " ovf"}, int'(bus11.overflow), int'(ovf));
    @(negedge clk);
  endtask
  initial begin
    int e2, e1, e0, n, cnt;
    bit en, eo;
    bus.in_valid = 1'b0; bus.in_value = '0;
    bus11.in_valid = 1'b0; bus11.in_value = '0;
    tbl[0] = '{123, 1, 2, 3, 0, 0};
    tbl[1] = '{-45, 0, 4, 5, 1, 0};
    tbl[2] = '{0, 0, 0, 0, 0, 0};
    tbl[3] = '{-512, 5, 1, 2, 1, 0};
    tbl[4] = '{511, 5, 1, 1, 0, 0};
    tbl[5] = '{-1, 0, 0, 1, 1, 0};
    tbl[6] = '{100, 1, 0, 0, 0, 0};
    tbl[7] = '{-7, 0, 0, 7, 1, 0};
    tbl[8] = '{90, 0, 9, 0, 0, 0};
    tbl[9] = '{-300, 3, 0, 0, 1, 0};
    #2 rst = 1'b0;
    #1;
    check_out("reset", 0, 0, 0, 0, 0, 0);
    chk("reset ready", int'(bus.in_ready), 1);
    chk("reset done", int'(bus.done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    repeat (5) begin @(negedge clk); cnt += int'(bus.done); end
    chk("idle no_done", cnt, 0);
    check_out("idle", 0, 0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      e2 = tbl[i].d2; e1 = tbl[i].d1; e0 = tbl[i].d0;
      blank(e2, e1);
      send(tbl[i].v, e2, e1, e0, tbl[i].neg, tbl[i].ovf, $sformatf("tbl%0d", i));
    end
    // back-to-back with in_valid held: second value must wait for in_ready
    wait_ready("b2b");
    bus.in_valid = 1'b1;
    bus.in_value = 10'(-512);
    @(posedge clk);
    @(negedge clk);
    bus.in_value = 10'(511);
    n = 0;
    wait_done(n, "b2b first", 11);
    check_out("b2b first", 5, 1, 2, 1, 0, 1);
    chk("b2b ready", int'(bus.in_ready), 1);
    @(negedge clk);
    n++;
    bus.in_valid = 1'b0;
    chk("b2b second_busy", int'(bus.in_ready), 0);
    check_out("b2b hold", 5, 1, 2, 1, 0, 1);
    wait_done(n, "b2b second", 23);
    check_out("b2b second", 5, 1, 1, 0, 0, 1);
    p2 = 5; p1 = 1; p0 = 1; pneg = 0; povf = 0; pen = 1;
    @(negedge clk);
    // reset mid-conversion
    wait_ready("rstmid");
    bus.in_valid = 1'b1;
    bus.in_value = 10'(777);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check_out("rstmid", 0, 0, 0, 0, 0, 0);
    chk("rstmid ready", int'(bus.in_ready), 1);
    chk("rstmid done", int'(bus.done), 0);
    @(negedge clk);
    rst = 1'b1;
    p2 = 0; p1 = 0; p0 = 0; pneg = 0; povf = 0; pen = 0;
    cnt = 0;
    repeat (15) begin @(negedge clk); cnt += int'(bus.done); end
    chk("rstmid no_done", cnt, 0);
    e2 = 0; e1 = 0;
    blank(e2, e1);
    send(8, e2, e1, 8, 0, 0, "after_rst");
    for (int i = 0; i < 30; i++) begin
      int v;
      v = int'($urandom_range(0, 1023)) - 512;
      model(v, e2, e1, e0, en, eo);
      send(v, e2, e1, e0, en, eo, $sformatf("rnd%0d(%0d)", i, v));
    end
    foreach (tbl[i]) ;
    begin
      int w11[6] = '{1023, -1024, 1000, 999, -999, 0};
      foreach (w11[i]) begin
        model(w11[i], e2, e1, e0, en, eo);
        send11(w11[i], e2, e1, e0, en, eo, $sformatf("w11_%0d", w11[i]));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
